// File: rtl/npu_layer_seq.sv
// Layer-pass sequencer for the two-neuron NPU datapath: clear, accumulate NUM_BEATS beats,
// drain the MAC pipe, bias, activate, then write N1 and N2 into the output FIFO.
module npu_layer_seq #(
  parameter int CNT_W    = 8,
  parameter int PIPE_LAT = 2,
  parameter int ACT_LAT  = 1
) (
  input  logic             CLKEXT,
  input  logic             RST_GLO,
  input  logic             START,
  input  logic             ABORT,
  input  logic [CNT_W-1:0] NUM_BEATS,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic             FIFO_FULL,
  output logic             CLR_ACC,
  output logic             MAC_EN,
  output logic             BIAS_EN,
  output logic             ACT_EN,
  output logic             FIFO_WR,
  output logic             OUT_SEL,
  output logic [CNT_W-1:0] BEAT_CNT,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR
);

  localparam int SUB_W = 8;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_CLEAR  = 4'd1,
    S_ACCUM  = 4'd2,
    S_DRAIN  = 4'd3,
    S_BIAS   = 4'd4,
    S_ACT    = 4'd5,
    S_WR_N1  = 4'd6,
    S_WR_N2  = 4'd7,
    S_FINISH = 4'd8
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0]   num_q, num_d;
  logic [SUB_W-1:0]   sub_q, sub_d;
  logic               err_q, err_d;

  // State and counter registers
  always_ff @(posedge CLKEXT or posedge RST_GLO) begin
    if (RST_GLO) begin
      state_q    <= S_IDLE;
      beat_cnt_q <= '0;
      num_q      <= '0;
      sub_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      num_q      <= num_d;
      sub_q      <= sub_d;
      err_q      <= err_d;
    end
  end

  // Next-state logic; an abort from any busy state overrides the normal transition
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    num_d      = num_q;
    sub_d      = sub_q;
    err_d      = 1'b0;
    if (ABORT && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      sub_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (START && (NUM_BEATS != '0)) begin
            state_d = S_CLEAR;
            num_d   = NUM_BEATS;
          end else begin
            err_d = START;
          end
        end
        S_CLEAR: begin
          beat_cnt_d = '0;
          sub_d      = '0;
          state_d    = S_ACCUM;
        end
        S_ACCUM: begin
          if (IN_VALID) begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
            if (beat_cnt_q == (num_q - CNT_W'(1))) begin
              sub_d   = '0;
              state_d = (PIPE_LAT > 0) ? S_DRAIN : S_BIAS;
            end else begin
              state_d = S_ACCUM;
            end
          end else begin
            state_d = S_ACCUM;
          end
        end
        S_DRAIN: begin
          if (sub_q == SUB_W'(PIPE_LAT - 1)) begin
            sub_d   = '0;
            state_d = S_BIAS;
          end else begin
            sub_d = sub_q + SUB_W'(1);
          end
        end
        S_BIAS: begin
          sub_d   = '0;
          state_d = S_ACT;
        end
        // ACT_EN fires on the first cycle; remaining ACT_LAT cycles let the result settle
        S_ACT: begin
          if (sub_q == SUB_W'(ACT_LAT)) begin
            sub_d   = '0;
            state_d = S_WR_N1;
          end else begin
            sub_d = sub_q + SUB_W'(1);
          end
        end
        S_WR_N1: state_d = FIFO_FULL ? S_WR_N1 : S_WR_N2;
        S_WR_N2: state_d = FIFO_FULL ? S_WR_N2 : S_FINISH;
        S_FINISH: state_d = S_IDLE;
        default: begin
          state_d = S_IDLE;
          sub_d   = '0;
        end
      endcase
    end
  end

  assign IN_READY = (state_q == S_ACCUM);
  assign MAC_EN   = (state_q == S_ACCUM) && IN_VALID;
  assign CLR_ACC  = (state_q == S_CLEAR);
  assign BIAS_EN  = (state_q == S_BIAS);
  assign ACT_EN   = (state_q == S_ACT) && (sub_q == '0);
  assign FIFO_WR  = ((state_q == S_WR_N1) || (state_q == S_WR_N2)) && !FIFO_FULL;
  assign OUT_SEL  = (state_q == S_WR_N2);
  assign BUSY     = (state_q != S_IDLE);
  assign DONE     = (state_q == S_FINISH);
  assign ERR      = err_q;
  assign BEAT_CNT = beat_cnt_q;

endmodule
